mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: N, default 32, requester data/address width; ADDR_W, default 13, byte-memory address width (2**13 = 8192 bytes).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req, cpu_we, cpu_byte  input  1 each  pipeline request, write (1) / read (0), byte (1) / word (0) access.
REQ-005 cpu_addr, cpu_wdata  input  N each  byte address; write data.
REQ-006 cpu_rdata  output  N  read data; cpu_ack  output  1  completion pulse; cpu_err  output  1  error, valid with ack.
REQ-007 eng_req, eng_we, eng_byte, eng_addr, eng_wdata, eng_rdata, eng_ack, eng_err SHALL mirror REQ-004..006 for the convolution engine port.
REQ-008 mem_addr  output  ADDR_W  byte address to data memory.
REQ-009 mem_wdata  output  8  byte write data; mem_rdata  input  8  byte read data.
REQ-010 mem_re, mem_we  output  1 each  edge-triggered memory strobes.

Function
REQ-011 FSM states SHALL be IDLE, STROBE, RECOVER, ACK.
REQ-012 In IDLE, with any request pending, the arbiter SHALL grant round-robin, latch the winner's we/byte/addr/wdata, clear the byte index k, then go to STROBE; with no request pending it SHALL stay in IDLE.
REQ-013 On a simultaneous request, the requester not granted last SHALL win; last-grant SHALL reset to engine, so the CPU wins the first tie.
REQ-014 STROBE SHALL assert exactly one of mem_re/mem_we for one cycle, with mem_addr = addr+k and mem_wdata = wdata[8k+7:8k]; then go to RECOVER.
REQ-015 RECOVER SHALL hold both strobes low, so every strobe is a fresh rising edge.
REQ-016 On a read, RECOVER SHALL capture mem_rdata into result byte k.
REQ-017 After RECOVER, the FSM SHALL go to STROBE with k+1 if bytes remain (1 byte for byte access, 4 for word), else to ACK.
REQ-018 ACK SHALL pulse the granted port's ack for one cycle, driving rdata, then return to IDLE.
REQ-019 Byte order SHALL be little-endian; no alignment is required.
REQ-020 A byte read SHALL return {24'b0, byte}; a byte write SHALL use wdata[7:0] only.
REQ-021 Latency from grant cycle 0 SHALL be: byte access ack at cycle 3; word access ack at cycle 9.
REQ-022 If addr >= 8192 (byte access) or addr+3 >= 8192 (word access), the FSM SHALL go directly to ACK: ack=1, err=1 at cycle 1, no strobe, rdata=0.
REQ-023 Requests SHALL be held until ack; a request deasserted mid-transfer SHALL be ignored and the transfer completes.
REQ-024 A request still high in the cycle after ack SHALL be treated as a new request.
REQ-025 The non-granted port's ack/err SHALL stay 0; its rdata SHALL hold its last value.
REQ-026 mem_re and mem_we SHALL never be high together.

Reset
REQ-027 On rst_n=0, the block SHALL immediately force state IDLE, all strobes/acks/errs 0, rdata 0, mem_addr 0, mem_wdata 0, k 0, last-grant = engine.
REQ-028 A reset mid-word SHALL abort the access; bytes already written stay written, and no ack is issued.

Structure
REQ-029 A shared package mem_arb_pkg SHALL hold the state enum, the requester-id enum, ADDR_W, and MEM_BYTES=8192.
REQ-030 The two-way round-robin decision SHALL be a sub-module rr_arb2 (req[1:0], last-grant in, grant one-hot out, purely combinational); the FSM and datapath stay in mem_arbiter.

Verification
REQ-031 CPU word write addr 0x100, data 0xDEADBEEF -> mem_we pulses at cycles 1,3,5,7 with bytes EF,BE,AD,DE to addrs 0x100-0x103; cpu_ack at cycle 9.
REQ-032 Engine byte read addr 0x064, memory byte 0x7F -> eng_rdata = 0x0000007F; eng_ack at cycle 3; mem_re pulses once.
REQ-033 CPU and engine request in the same cycle after reset -> CPU served first, then engine; repeated simultaneous requests alternate.
REQ-034 CPU word read addr 0x1FFE -> cpu_ack=1 and cpu_err=1 at cycle 1; no strobe; cpu_rdata=0.
REQ-035 Word write in progress, rst_n low at cycle 4 -> strobes drop immediately; state IDLE; no ack; bytes 0-1 written, bytes 2-3 unchanged.
REQ-036 Continuous assertion check: mem_re and mem_we are never both high, and no strobe is high for two consecutive cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port byte-memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W = 13;
  localparam int MEM_BYTES = 8192;
  typedef enum logic [1:0] {IDLE, STROBE, RECOVER, ACK} state_t;
  typedef enum logic {ID_CPU, ID_ENG} req_id_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the side not granted last wins
module rr_arb2 import mem_arb_pkg::*; (
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic [1:0] gnt
);
  assign gnt = &req ? (last == ID_ENG ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates CPU and engine word/byte accesses onto a byte-wide strobed memory
module mem_arbiter #(
  parameter int N = 32,
  parameter int ADDR_W = mem_arb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [N-1:0]      cpu_addr,
  input  logic [N-1:0]      cpu_wdata,
  output logic [N-1:0]      cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic              eng_byte,
  input  logic [N-1:0]      eng_addr,
  input  logic [N-1:0]      eng_wdata,
  output logic [N-1:0]      eng_rdata,
  output logic              eng_ack,
  output logic              eng_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_re,
  output logic              mem_we
);
  import mem_arb_pkg::*;
  state_t state, state_n;
  req_id_t last, owner, win, fin_id;
  logic we_q, byte_q, err_q, bad, done, load;
  logic [1:0] gnt, k;
  logic [N-1:0] addr_q, wdata_q, res, res_n, fin_val, sel_addr;
  logic [N:0] last_byte;
  rr_arb2 u_rr (.req({eng_req, cpu_req}), .last(last), .gnt(gnt));
  assign win = gnt[0] ? ID_CPU : ID_ENG;
  assign sel_addr = gnt[0] ? cpu_addr : eng_addr;
  // widened by one bit so an address near the top of the N-bit range cannot wrap past the bound
  assign last_byte = {1'b0, sel_addr} + (N+1)'((gnt[0] ? cpu_byte : eng_byte) ? 0 : 3);
  assign bad = last_byte >= (N+1)'(MEM_BYTES);
  assign done = k == (byte_q ? 2'd0 : 2'd3);
  assign load = (state == RECOVER && done) || (state == IDLE && |gnt && bad);
  assign fin_id = state == IDLE ? win : owner;
  assign fin_val = state == IDLE ? '0 : res_n;
  assign mem_re = state == STROBE && !we_q;
  assign mem_we = state == STROBE && we_q;
  assign mem_addr = ADDR_W'(addr_q + N'(k));
  assign mem_wdata = wdata_q[8*k +: 8];
  assign cpu_ack = state == ACK && owner == ID_CPU;
  assign eng_ack = state == ACK && owner == ID_ENG;
  assign cpu_err = cpu_ack && err_q;
  assign eng_err = eng_ack && err_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |gnt ? (bad ? ACK : STROBE) : IDLE;
      STROBE:  state_n = RECOVER;
      RECOVER: state_n = done ? ACK : STROBE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    res_n = res;
    if (!we_q) res_n[8*k +: 8] = mem_rdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= ID_ENG;
      owner <= ID_CPU;
      we_q <= 1'b0;
      byte_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      res <= '0;
      k <= 2'd0;
      cpu_rdata <= '0;
      eng_rdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |gnt) begin
        owner <= win;
        last <= win;
        we_q <= gnt[0] ? cpu_we : eng_we;
        byte_q <= gnt[0] ? cpu_byte : eng_byte;
        addr_q <= sel_addr;
        wdata_q <= gnt[0] ? cpu_wdata : eng_wdata;
        err_q <= bad;
        res <= '0;
        k <= 2'd0;
      end
      if (state == RECOVER) begin
        res <= res_n;
        if (!done) k <= k + 2'd1;
      end
      if (load && fin_id == ID_CPU) cpu_rdata <= fin_val;
      if (load && fin_id == ID_ENG) eng_rdata <= fin_val;
    end
  end
endmodule
